mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage (loads/stores).
- Serialises each 1/2/4-byte access into byte transfers, little-endian, and returns a one-cycle done pulse.
- Raises per-requester stall requests that the pipeline controller folds into stall[5:0], so the IF/ID and EX/MEM pipeline registers hold while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- MEM_FIRST, 1. 1 = MEM wins a same-cycle conflict; 0 = IF wins.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global ready; low = freeze
- if_req_in  input  1  IF access request (level, held until done)
- if_addr_in  input  ADDR_WIDTH  fetch address
- if_done_out  output  1  one-cycle pulse; if_inst_out valid this cycle
- if_inst_out  output  32  fetched word
- mem_req_in  input  1  MEM access request (level, held until done)
- mem_we_in  input  1  1 = store, 0 = load
- mem_len_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_addr_in  input  ADDR_WIDTH  load/store base address
- mem_wdata_in  input  32  store data; low bytes used
- mem_done_out  output  1  one-cycle pulse; mem_rdata_out valid this cycle
- mem_rdata_out  output  32  load data, zero-extended
- stallreq_if_out  output  1  if_req_in & ~if_done_out (combinational)
- stallreq_mem_out  output  1  mem_req_in & ~mem_done_out (combinational)
- ram_din  input  8  RAM read byte; valid one cycle after its address
- ram_dout  output  8  RAM write byte
- ram_a  output  ADDR_WIDTH  RAM byte address
- ram_wr  output  1  1 = write

Behaviour:
- FSM states: IDLE, RD, WR, DONE.
- Reset: state IDLE. All outputs 0 except the combinational stall requests.
- Reset asserted mid-transaction: immediate IDLE, no done pulse, ram_wr 0.
- Grant (IDLE only): if both requests are high, priority follows MEM_FIRST. The request fields are latched at the grant edge G.
  - IF is always a 4-byte read.
  - MEM takes N = 1/2/4 bytes from mem_len_in.
- Define cycle k = the k-th cycle after edge G (k = 0, 1, ...).
- Read (N bytes):
  - ram_a = base+k in cycles 0..N-1, with ram_wr = 0.
  - Byte k is captured from ram_din at the end of cycle k+1, into bits [8k+7:8k].
  - DONE in cycle N+1: the requester's done pulses and its data output is valid; unused upper bytes are 0.
- Write (N bytes): ram_wr = 1, ram_a = base+k, ram_dout = wdata[8k+7:8k] in cycles 0..N-1. DONE in cycle N.
- DONE always lasts 1 cycle, then IDLE. Requests are ignored during DONE, so the requester has one cycle to drop or change its request. The earliest next grant is the edge ending the following IDLE cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Outputs outside a transfer: ram_a = 0, ram_dout = 0, ram_wr = 0.
- rdy_in low: all state, counters and captured data hold; ram_wr is gated to 0. The RAM is required to hold ram_din while rdy_in is low.
- Done outputs are registered. if_inst_out / mem_rdata_out keep their last value after done.
- No write-after-read reordering: exactly one transaction is outstanding at a time.

Optional Feature:
- Macro: IF_ABORT_EN.
- Defined:
  - Adds input if_abort_in (1 bit, from branch/jump flush).
  - High during any RD cycle of an IF transaction: IDLE at the next edge, no if_done_out, captured bytes discarded.
  - High in IDLE: IF is not eligible for grant that cycle.
  - MEM transactions are unaffected.
- Undefined: the port is absent; IF transactions always run to completion.

Test Plan:
- IF fetch only: if_addr_in=0x100, RAM bytes 13,05,00,00 → ram_a 0x100..0x103 in cycles 0-3; if_done_out=1 in cycle 5 with if_inst_out=0x00000513; IDLE in cycle 6.
- Same-cycle conflict, MEM_FIRST=1: IF 0x200 plus MEM word store 0x1000 data 0xDEADBEEF → writes EF,BE,AD,DE to 0x1000..0x1003, mem_done_out in cycle 4; IF granted next, if_done_out 7 cycles after mem_done_out.
- Byte load at 0x3: ram_din=0x80 → mem_rdata_out=0x00000080 in cycle 2; stallreq_mem_out high cycles 0-1, low in cycle 2.
- Half store wrap: addr 0xFFFFFFFF, data 0x1234 → ram_a 0xFFFFFFFF then 0x00000000, bytes 34, 12; done in cycle 2.
- rdy_in low 3 cycles during cycle 2 of a word read → ram_a holds, no capture, done delayed exactly 3 cycles, value correct; rst_in pulse in cycle 1 of a store → ram_wr 0 immediately, no done, IDLE.
- IF_ABORT_EN: if_abort_in in cycle 2 of a fetch → no if_done_out, IDLE next cycle, pending MEM load granted at the following IDLE edge.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the byte-wide RAM and mem_arbiter.
// When IF_ABORT_EN is defined the bundle also carries the IF flush input.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  rdy_in;

    logic                  if_req_in;
    logic [ADDR_WIDTH-1:0] if_addr_in;
    logic                  if_done_out;
    logic [31:0]           if_inst_out;
`ifdef IF_ABORT_EN
    logic                  if_abort_in;
`endif

    logic                  mem_req_in;
    logic                  mem_we_in;
    logic [1:0]            mem_len_in;
    logic [ADDR_WIDTH-1:0] mem_addr_in;
    logic [31:0]           mem_wdata_in;
    logic                  mem_done_out;
    logic [31:0]           mem_rdata_out;

    logic                  stallreq_if_out;
    logic                  stallreq_mem_out;

    logic [7:0]            ram_din;
    logic [7:0]            ram_dout;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic                  ram_wr;

    // The arbiter side: it receives requests and drives the RAM port.
    modport slave (
        input  rdy_in,
        input  if_req_in, if_addr_in,
`ifdef IF_ABORT_EN
        input  if_abort_in,
`endif
        output if_done_out, if_inst_out,
        input  mem_req_in, mem_we_in, mem_len_in, mem_addr_in, mem_wdata_in,
        output mem_done_out, mem_rdata_out,
        output stallreq_if_out, stallreq_mem_out,
        input  ram_din,
        output ram_dout, ram_a, ram_wr
    );

    modport master (
        output rdy_in,
        output if_req_in, if_addr_in,
`ifdef IF_ABORT_EN
        output if_abort_in,
`endif
        input  if_done_out, if_inst_out,
        output mem_req_in, mem_we_in, mem_len_in, mem_addr_in, mem_wdata_in,
        input  mem_done_out, mem_rdata_out,
        input  stallreq_if_out, stallreq_mem_out,
        output ram_din,
        input  ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one byte-wide RAM port, one transfer at a time.
// Optional macro IF_ABORT_EN adds if_abort_in, which cancels an in-flight IF read.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_FIRST  = 1
) (
    input logic          clk_in,
    input logic          rst_in,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                state;
    state_t                next_state;

    logic                  owner_mem_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [2:0]            nbytes_q;
    logic [2:0]            cnt_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdbuf_q;
    logic                  if_done_q;
    logic                  mem_done_q;
    logic [31:0]           if_inst_q;
    logic [31:0]           mem_rdata_q;

    logic                  if_eligible;
    logic                  grant_mem;
    logic                  grant_if;
    logic                  abort_now;
    logic                  last_rd;
    logic                  last_wr;
    logic [2:0]            mem_nbytes;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           rdbuf_next;
    logic [7:0]            wr_byte;

    always_comb begin
        mem_nbytes = 3'd4;
        case (bus.mem_len_in)
            2'b00:   mem_nbytes = 3'd1;
            2'b01:   mem_nbytes = 3'd2;
            default: mem_nbytes = 3'd4;
        endcase
    end

    always_comb begin
        if_eligible = bus.if_req_in;
        abort_now   = 1'b0;
`ifdef IF_ABORT_EN
        if_eligible = bus.if_req_in && !bus.if_abort_in;
        abort_now   = (state == RD) && !owner_mem_q && bus.if_abort_in;
`endif
        grant_mem   = bus.mem_req_in && ((MEM_FIRST != 0) || !if_eligible);
        grant_if    = if_eligible && !grant_mem;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A read stays in RD one cycle past its last address to capture the trailing byte.
    always_comb begin
        next_state = state;
        last_rd    = (cnt_q == nbytes_q);
        last_wr    = (cnt_q == nbytes_q - 3'd1);
        if (bus.rdy_in) begin
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        next_state = bus.mem_we_in ? WR : RD;
                    end else if (grant_if) begin
                        next_state = RD;
                    end
                end
                RD: begin
                    if (abort_now) begin
                        next_state = IDLE;
                    end else if (last_rd) begin
                        next_state = DONE;
                    end
                end
                WR: begin
                    if (last_wr) begin
                        next_state = DONE;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        cur_addr   = base_q + ADDR_WIDTH'(cnt_q);
        rdbuf_next = rdbuf_q;
        case (cnt_q)
            3'd1:    rdbuf_next[7:0]   = bus.ram_din;
            3'd2:    rdbuf_next[15:8]  = bus.ram_din;
            3'd3:    rdbuf_next[23:16] = bus.ram_din;
            3'd4:    rdbuf_next[31:24] = bus.ram_din;
            default: rdbuf_next = rdbuf_q;
        endcase
        wr_byte = wdata_q[7:0];
        case (cnt_q[1:0])
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    // RAM port is idle (all zero) outside a transfer; writes are masked while frozen.
    always_comb begin
        bus.ram_a    = '0;
        bus.ram_dout = 8'h00;
        bus.ram_wr   = 1'b0;
        if ((state == RD) && (cnt_q < nbytes_q)) begin
            bus.ram_a = cur_addr;
        end else if (state == WR) begin
            bus.ram_a    = cur_addr;
            bus.ram_dout = wr_byte;
            bus.ram_wr   = bus.rdy_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            owner_mem_q <= 1'b0;
            base_q      <= '0;
            nbytes_q    <= 3'd0;
            cnt_q       <= 3'd0;
            wdata_q     <= 32'h0;
            rdbuf_q     <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else if (bus.rdy_in) begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt_q   <= 3'd0;
                    rdbuf_q <= 32'h0;
                    if (grant_mem) begin
                        owner_mem_q <= 1'b1;
                        base_q      <= bus.mem_addr_in;
                        nbytes_q    <= mem_nbytes;
                        wdata_q     <= bus.mem_wdata_in;
                    end else if (grant_if) begin
                        owner_mem_q <= 1'b0;
                        base_q      <= bus.if_addr_in;
                        nbytes_q    <= 3'd4;
                    end
                end
                RD: begin
                    if (!abort_now) begin
                        cnt_q   <= cnt_q + 3'd1;
                        rdbuf_q <= rdbuf_next;
                        if (last_rd) begin
                            if (owner_mem_q) begin
                                mem_done_q  <= 1'b1;
                                mem_rdata_q <= rdbuf_next;
                            end else begin
                                if_done_q <= 1'b1;
                                if_inst_q <= rdbuf_next;
                            end
                        end
                    end
                end
                WR: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (last_wr) begin
                        mem_done_q <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.if_done_out      = if_done_q;
    assign bus.if_inst_out      = if_inst_q;
    assign bus.mem_done_out     = mem_done_q;
    assign bus.mem_rdata_out    = mem_rdata_q;
    assign bus.stallreq_if_out  = bus.if_req_in && !if_done_q;
    assign bus.stallreq_mem_out = bus.mem_req_in && !mem_done_q;
endmodule
